// File: rtl/seg_step_gen_pkg.sv
// Shared state encoding, parameter defaults and channel slicing for the segment step generator.
package seg_step_gen_pkg;

   typedef enum logic [1:0] {S_IDLE, S_RUN, S_WAIT, S_ABORT} state_t;

   localparam int DEF_CHANNELS     = 3;
   localparam int DEF_W            = 32;
   localparam int DEF_WAIT_TIMEOUT = 1000;

   function automatic int chan_lo(input int ch, input int w);
      return ch * w;
   endfunction

endpackage

// File: rtl/seg_step_gen_if.sv
// Segment offer bus from the motion planner: per-channel interval/count with valid/ready handshake.
interface seg_step_gen_if
   import seg_step_gen_pkg::*;
#(
   parameter int CHANNELS = DEF_CHANNELS,
   parameter int W        = DEF_W
);
   logic                  seg_valid;
   logic                  seg_ready;
   logic [CHANNELS*W-1:0] seg_dt;
   logic [CHANNELS*W-1:0] seg_steps;

   modport master (output seg_valid, output seg_dt, output seg_steps, input seg_ready);
   modport slave  (input seg_valid, input seg_dt, input seg_steps, output seg_ready);
endinterface

// File: rtl/seg_step_gen_step_chan.sv
// One step channel: interval and step counters against loaded limits; registered strobe.
// chan_done is combinational and already accounts for the step firing on this edge.
module step_chan
   import seg_step_gen_pkg::*;
#(
   parameter int W = DEF_W
)(
   input  logic         clk,
   input  logic         reset,
   input  logic         load,
   input  logic [W-1:0] load_dt,
   input  logic [W-1:0] load_steps,
   input  logic         run,
   input  logic         abort_step,
   output logic         step_stb,
   output logic [W-1:0] steps,
   output logic         chan_done
);

   logic [W-1:0] dt;
   logic [W-1:0] dt_lim;
   logic [W-1:0] steps_lim;
   logic [W-1:0] dt_lim_eff;
   logic         active;
   logic         fire;

   // Compare at W+1 bits so an all-ones counter cannot wrap into a false match.
   always_comb begin
      dt_lim_eff = (dt_lim == '0) ? W'(1) : dt_lim;
      active     = run && (steps < steps_lim);
      fire       = active && (({1'b0, dt} + 1'b1) >= {1'b0, dt_lim_eff});
      chan_done  = !(steps < steps_lim) ||
                   (fire && (({1'b0, steps} + 1'b1) >= {1'b0, steps_lim}));
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         dt        <= '0;
         dt_lim    <= '0;
         steps     <= '0;
         steps_lim <= '0;
         step_stb  <= 1'b0;
      end else if (load) begin
         dt        <= '0;
         steps     <= '0;
         dt_lim    <= load_dt;
         steps_lim <= load_steps;
         step_stb  <= 1'b0;
      end else if (abort_step) begin
         steps    <= steps + 1'b1;
         step_stb <= 1'b1;
      end else if (fire) begin
         dt       <= '0;
         steps    <= steps + 1'b1;
         step_stb <= 1'b1;
      end else begin
         step_stb <= 1'b0;
         if (active) begin
            dt <= dt + 1'b1;
         end
      end
   end

endmodule

// File: rtl/seg_step_gen.sv
// Multi-channel step generator with a one-deep shadow segment; promote follows seg_done by one cycle.
// seg_ready is low while the shadow holds a segment; starvation times out from WAIT into ABORT stepping.
module seg_step_gen
   import seg_step_gen_pkg::*;
#(
   parameter int CHANNELS     = DEF_CHANNELS,
   parameter int W            = DEF_W,
   parameter int WAIT_TIMEOUT = DEF_WAIT_TIMEOUT
)(
   input  logic                  clk,
   input  logic                  reset,
   seg_step_gen_if.slave         seg,
   input  logic [W-1:0]          abort_dt,
   output logic [CHANNELS-1:0]   step_stb,
   output logic [CHANNELS*W-1:0] steps,
   output logic                  seg_done,
   output logic                  abort,
   output logic                  busy
);

   localparam logic [31:0] WAIT_LAST = 32'(WAIT_TIMEOUT - 1);

   state_t                state;
   logic                  shadow_full;
   logic                  shadow_full_next;
   logic [CHANNELS*W-1:0] sh_dt;
   logic [CHANNELS*W-1:0] sh_steps;
   logic [31:0]           wait_cnt;
   logic [W-1:0]          abort_cnt;
   logic [W-1:0]          abort_lim;
   logic [CHANNELS-1:0]   chan_done;
   logic                  accept;
   logic                  promote;
   logic                  abort_fire;
   logic                  all_done;

   // In RUN the shadow waits for the registered seg_done, giving back-to-back segments.
   always_comb begin
      accept           = seg.seg_valid && seg.seg_ready;
      promote          = shadow_full && ((state != S_RUN) || seg_done);
      shadow_full_next = (shadow_full && !promote) || accept;
      all_done         = &chan_done;
      abort_lim        = (abort_dt == '0) ? W'(1) : abort_dt;
      abort_fire       = (state == S_ABORT) && !promote &&
                         (({1'b0, abort_cnt} + 1'b1) >= {1'b0, abort_lim});
   end

   for (genvar i = 0; i < CHANNELS; i++) begin : g_chan
      step_chan #(.W(W)) u_chan (
         .clk        (clk),
         .reset      (reset),
         .load       (promote),
         .load_dt    (sh_dt[chan_lo(i, W) +: W]),
         .load_steps (sh_steps[chan_lo(i, W) +: W]),
         .run        (state == S_RUN),
         .abort_step (abort_fire),
         .step_stb   (step_stb[i]),
         .steps      (steps[chan_lo(i, W) +: W]),
         .chan_done  (chan_done[i])
      );
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state         <= S_IDLE;
         shadow_full   <= 1'b0;
         seg.seg_ready <= 1'b1;
         sh_dt         <= '0;
         sh_steps      <= '0;
         wait_cnt      <= '0;
         abort_cnt     <= '0;
         seg_done      <= 1'b0;
         abort         <= 1'b0;
         busy          <= 1'b0;
      end else begin
         shadow_full   <= shadow_full_next;
         seg.seg_ready <= !shadow_full_next;
         if (accept) begin
            sh_dt    <= seg.seg_dt;
            sh_steps <= seg.seg_steps;
         end
         busy     <= (state != S_IDLE) || promote;
         seg_done <= 1'b0;

         case (state)
            S_IDLE: begin
               if (promote) state <= S_RUN;
            end
            S_RUN: begin
               if (seg_done) begin
                  if (!promote) begin
                     state    <= S_WAIT;
                     wait_cnt <= '0;
                  end
               end else if (all_done) begin
                  seg_done <= 1'b1;
               end
            end
            S_WAIT: begin
               if (promote) begin
                  state <= S_RUN;
               end else if (wait_cnt == WAIT_LAST) begin
                  state     <= S_ABORT;
                  abort     <= 1'b1;
                  abort_cnt <= '0;
               end else begin
                  wait_cnt <= wait_cnt + 32'd1;
               end
            end
            S_ABORT: begin
               if (promote) begin
                  state <= S_RUN;
                  abort <= 1'b0;
               end else if (abort_fire) begin
                  abort_cnt <= '0;
               end else begin
                  abort_cnt <= abort_cnt + 1'b1;
               end
            end
            default: state <= S_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_seg_step_gen.sv
// Bench for seg_step_gen: directed segments plus random ones against an arithmetic pulse-schedule model.
module tb_seg_step_gen;

   localparam int CH  = 3;
   localparam int W   = 32;
   localparam int TO  = 10;
   localparam int ADT = 4;

   typedef int arr_t [CH];

   logic            clk = 1'b0;
   logic            reset;
   logic [W-1:0]    abort_dt;
   logic [CH-1:0]   step_stb;
   logic [CH*W-1:0] steps;
   logic            seg_done;
   logic            abort;
   logic            busy;

   int   checks = 0;
   int   errors = 0;
   arr_t a_d, a_n, b_d, b_n, c_d, c_n, z_d, z_n, r_d, r_n;

   seg_step_gen_if #(.CHANNELS(CH), .W(W)) sif ();

   seg_step_gen #(.CHANNELS(CH), .W(W), .WAIT_TIMEOUT(TO)) dut (
      .clk      (clk),
      .reset    (reset),
      .seg      (sif.slave),
      .abort_dt (abort_dt),
      .step_stb (step_stb),
      .steps    (steps),
      .seg_done (seg_done),
      .abort    (abort),
      .busy     (busy)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   function automatic int eff(input int d);
      return (d == 0) ? 1 : d;
   endfunction

   // A segment ends when its slowest channel finishes, or one cycle in if nothing steps.
   function automatic int seg_len(input arr_t d, input arr_t n);
      int m;
      m = 1;
      for (int i = 0; i < CH; i++)
         if (n[i] * eff(d[i]) > m) m = n[i] * eff(d[i]);
      return m;
   endfunction

   task automatic tick();
      logic acc;
      acc = sif.seg_valid && sif.seg_ready;
      @(posedge clk);
      #1;
      if (acc) sif.seg_valid = 1'b0;
   endtask

   task automatic offer(input arr_t d, input arr_t n);
      for (int i = 0; i < CH; i++) begin
         sif.seg_dt[i*W +: W]    = W'(d[i]);
         sif.seg_steps[i*W +: W] = W'(n[i]);
      end
      sif.seg_valid = 1'b1;
   endtask

   task automatic chk_steps(input string tag, input arr_t n);
      for (int i = 0; i < CH; i++)
         chk($sformatf("%s_ch%0d", tag, i), steps[i*W +: W], n[i]);
   endtask

   // Channel i pulses at cycles e, 2e, .. n*e after promote (e = dt, 0 treated as 1).
   task automatic check_seg(input arr_t d, input arr_t n, input int c_from, input int c_to);
      int dl;
      dl = seg_len(d, n);
      for (int c = c_from; c <= c_to; c++) begin
         logic [CH-1:0] es;
         int e;
         tick();
         es = '0;
         for (int i = 0; i < CH; i++) begin
            e = eff(d[i]);
            es[i] = (c % e == 0) && (c / e >= 1) && (c / e <= n[i]);
            chk($sformatf("steps_ch%0d_c%0d", i, c), steps[i*W +: W], (c / e < n[i]) ? c / e : n[i]);
         end
         chk($sformatf("step_stb_c%0d", c), step_stb, es);
         chk($sformatf("seg_done_c%0d", c), seg_done, c == dl);
         chk($sformatf("busy_abort_c%0d", c), {busy, abort}, 2'b10);
      end
   endtask

   task automatic run_seg(input arr_t d, input arr_t n);
      offer(d, n);
      chk("ready_idle", sif.seg_ready, 1);
      tick();
      chk("ready_shadow_full", sif.seg_ready, 0);
      chk("stb_on_accept", step_stb, 0);
      tick();
      chk("ready_after_promote", sif.seg_ready, 1);
      chk("busy_after_promote", busy, 1);
      chk_steps("steps_after_promote", '{0, 0, 0});
      check_seg(d, n, 1, seg_len(d, n));
      tick();
      chk("wait_entry_done", seg_done, 0);
      chk("wait_entry_stb", step_stb, 0);
      chk_steps("wait_entry_steps", n);
   endtask

   initial begin
      reset         = 1'b1;
      abort_dt      = W'(ADT);
      sif.seg_valid = 1'b0;
      sif.seg_dt    = '0;
      sif.seg_steps = '0;
      a_d = '{2, 3, 6};  a_n = '{6, 4, 2};
      c_d = '{1, 1, 1};  c_n = '{2, 2, 2};
      z_d = '{7, 0, 7};  z_n = '{0, 5, 0};

      repeat (3) tick();
      chk("rst_stb", step_stb, 0);
      chk("rst_done", seg_done, 0);
      chk("rst_abort", abort, 0);
      chk("rst_busy", busy, 0);
      chk("rst_ready", sif.seg_ready, 1);
      chk_steps("rst_steps", '{0, 0, 0});
      reset = 1'b0;
      tick();
      chk("idle_busy", busy, 0);

      // Segment A with a random segment B queued behind it.
      offer(a_d, a_n);
      tick();
      chk("a_ready_full", sif.seg_ready, 0);
      chk("a_busy_accept", busy, 0);
      tick();
      chk("a_busy_promote", busy, 1);
      chk("a_ready_promote", sif.seg_ready, 1);
      for (int i = 0; i < CH; i++) begin
         b_d[i] = int'($urandom_range(5, 0));
         b_n[i] = int'($urandom_range(5, 0));
      end
      offer(b_d, b_n);
      check_seg(a_d, a_n, 1, seg_len(a_d, a_n));
      chk("a_done_12", seg_done, 1);
      chk("a_ready_held", sif.seg_ready, 0);
      tick();
      chk("b_ready_promote", sif.seg_ready, 1);
      chk("b_stb_promote", step_stb, 0);
      chk("b_done_promote", seg_done, 0);
      chk_steps("b_steps_promote", '{0, 0, 0});
      check_seg(b_d, b_n, 1, seg_len(b_d, b_n));
      tick();
      chk("b_wait_stb", step_stb, 0);

      // Starve: WAIT for TO cycles, then ABORT stepping every ADT cycles.
      for (int k = 1; k <= 24; k++) begin
         tick();
         chk($sformatf("wait_abort_k%0d", k), abort, k >= TO);
         chk($sformatf("wait_stb_k%0d", k), step_stb,
             (k > TO && (k - TO) % ADT == 0) ? 3'b111 : 3'b000);
         chk($sformatf("wait_busy_k%0d", k), busy, 1);
         for (int i = 0; i < CH; i++)
            chk($sformatf("wait_steps_ch%0d_k%0d", i, k), steps[i*W +: W],
                b_n[i] + ((k >= TO) ? (k - TO) / ADT : 0));
      end

      // Promote lands on an abort-step edge: the new segment wins.
      offer(c_d, c_n);
      tick();
      chk("c_abort_accept", abort, 1);
      chk("c_ready_full", sif.seg_ready, 0);
      tick();
      chk("c_abort_promote", abort, 0);
      chk("c_stb_promote", step_stb, 0);
      chk_steps("c_steps_promote", '{0, 0, 0});
      check_seg(c_d, c_n, 1, seg_len(c_d, c_n));
      tick();
      chk("c_wait_stb", step_stb, 0);

      run_seg(z_d, z_n);

      repeat (6) begin
         for (int i = 0; i < CH; i++) begin
            r_d[i] = int'($urandom_range(5, 0));
            r_n[i] = int'($urandom_range(5, 0));
         end
         run_seg(r_d, r_n);
      end

      // Reset in the middle of RUN with the shadow occupied.
      offer(a_d, a_n);
      tick();
      tick();
      offer(c_d, c_n);
      tick();
      tick();
      chk("mid_ready_full", sif.seg_ready, 0);
      chk("mid_busy", busy, 1);
      reset = 1'b1;
      tick();
      chk("mrst_stb", step_stb, 0);
      chk("mrst_done", seg_done, 0);
      chk("mrst_abort", abort, 0);
      chk("mrst_busy", busy, 0);
      chk("mrst_ready", sif.seg_ready, 1);
      chk_steps("mrst_steps", '{0, 0, 0});
      reset = 1'b0;
      for (int k = 1; k <= 20; k++) begin
         tick();
         chk($sformatf("post_rst_k%0d", k), {step_stb, seg_done, abort, busy}, 0);
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
